grf_scoreboard: RTL
===================

# grf_scoreboard

Parametrised general-purpose register file for the D stage, successor to the fixed 32×32 two-read GRF. Width, depth and read-port count are parameters, and each register carries an in-flight write counter (scoreboard). The decode stage therefore gets data plus a per-port busy flag, and can stall on true RAW hazards without relying on external hazard tables. Also provides flush of pending state and a sticky scoreboard error flag.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register address width; depth = 2^ADDR_W.
- `NRD`, default 2: number of read ports.
- `CNT_W`, default 2: in-flight counter width; max pending writes per register = 2^CNT_W − 1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears array, counters and error flag.
- `in_raddr` input NRD·ADDR_W: packed read addresses; port k uses bits [k·ADDR_W +: ADDR_W].
- `out_rdata` output NRD·DATA_W: packed read data, combinational.
- `out_rbusy` output NRD: port k's register has an uncommitted pending write.
- `in_issue` input 1: an instruction with a destination leaves D this cycle.
- `in_issue_addr` input ADDR_W: that destination register.
- `out_issue_stall` output 1: `in_issue_addr` counter is saturated; the issue is refused.
- `in_we` input 1: writeback enable.
- `in_waddr` input ADDR_W: writeback register.
- `in_wdata` input DATA_W: writeback data.
- `in_flush` input 1: synchronous clear of all counters; register contents kept.
- `out_sb_err` output 1: sticky; set when a writeback hits a register with counter 0 (other than r0).

## Operation
- Register 0: reads always return 0. Never written, never pending. Issue to r0 is ignored and never stalls.
- Read port k: data = `grf[in_raddr[k]]`, subject to forwarding (see Configuration). `out_rbusy[k]` = (cnt[addr] ≠ 0), modified by forwarding.
- Write: when `in_we` and `in_waddr` ≠ 0, `grf[in_waddr]` ← `in_wdata` at the posedge.
- Counter update per register r at posedge, with inc = `in_issue` && `in_issue_addr`==r && r≠0 && !`out_issue_stall`, and dec = `in_we` && `in_waddr`==r && r≠0 && cnt[r]≠0:
  - inc only → +1.
  - dec only → −1.
  - both → unchanged.
- `out_issue_stall` = `in_issue` && addr≠0 && cnt[addr] == max && !(dec to the same addr this cycle). Combinational.
- Writeback to r≠0 with cnt[r]==0: the data is still written, the counter stays 0, and `out_sb_err` is set.
- `in_flush`: all counters → 0 at the posedge. Flush overrides a same-cycle issue and dec. The writeback data of that cycle is still committed.

## Timing
- Reads: zero latency, combinational. Writes and counter changes become visible from the cycle after the posedge.
- Reset values:
  - `out_rdata` all 0.
  - `out_rbusy` all 0.
  - `out_issue_stall` 0.
  - `out_sb_err` 0.
  - All counters and array entries 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). Inputs are ignored while reset is high.
- `out_sb_err` is cleared only by reset, not by flush.

## Configuration
- `GRF_FWD_EN` defined:
  - Read of addr≠0 equal to `in_waddr` while `in_we` returns `in_wdata`.
  - If additionally cnt[addr]==1 and no same-cycle issue to addr, `out_rbusy[k]`=0.
- `GRF_FWD_EN` undefined:
  - Reads return array contents only.
  - `out_rbusy[k]` = (cnt[addr] ≠ 0). Hazard logic must stall one extra cycle after writeback.

## Structure
- Package `grf_pkg`:
  - Default `DATA_W`/`ADDR_W`/`CNT_W` localparams.
  - Counter-max helper constant.
  - `grf_cnt_t` typedef.
- Sub-module `grf_pend_ctr`: one per register, built in a generate loop.
  - Inputs: inc, dec, flush.
  - Outputs: cnt, sat.
  - Asynchronous reset.
- Top level holds the array, the read muxes, forwarding, and the error flag.

## Test plan
- Reset then read r0..r31 on both ports → all data 0, busy 0, `out_sb_err` 0.
- Issue r5; next cycle read r5 → busy=1. Write r5=0xDEADBEEF with read r5 same cycle → data 0xDEADBEEF, busy 0 (FWD on); array data, busy 1 (FWD off). Cycle after → 0xDEADBEEF, busy 0.
- Issue r7 three times → cnt 3. Fourth issue → `out_issue_stall`=1, cnt stays 3. Fourth issue plus same-cycle write r7 → no stall, cnt 3.
- Write r9 with cnt 0 → r9 updated, `out_sb_err`=1, stays 1 through `in_flush`. Cleared only by reset.
- Issue r3 and r4, then `in_flush` with simultaneous issue r6 → all busy 0 next cycle. r3/r4 keep their old data.
- Write r0=0x1234 and issue r0 → reads of r0 stay 0, never busy, no stall, no error.

Source files
------------

// File: rtl/grf_scoreboard_pkg.sv
// grf_pkg: shared defaults, counter-max helper and counter type
// for the scoreboarded general-purpose register file.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_CNT_W  = 2;

  function automatic int grf_cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int GRF_CNT_MAX = grf_cnt_max(GRF_CNT_W);

  typedef logic [GRF_CNT_W-1:0] grf_cnt_t;

endpackage

// File: rtl/grf_scoreboard_if.sv
// grf_scoreboard_if: decode-side bundle (reads, issue, writeback,
// flush, error). master = decode/WB side, slave = register file.
interface grf_scoreboard_if
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NRD    = 2
);

  logic [NRD*ADDR_W-1:0] in_raddr;
  logic [NRD*DATA_W-1:0] out_rdata;
  logic [NRD-1:0]        out_rbusy;
  logic                  in_issue;
  logic [ADDR_W-1:0]     in_issue_addr;
  logic                  out_issue_stall;
  logic                  in_we;
  logic [ADDR_W-1:0]     in_waddr;
  logic [DATA_W-1:0]     in_wdata;
  logic                  in_flush;
  logic                  out_sb_err;

  modport master (
    output in_raddr, in_issue, in_issue_addr,
    output in_we, in_waddr, in_wdata, in_flush,
    input  out_rdata, out_rbusy,
    input  out_issue_stall, out_sb_err
  );

  modport slave (
    input  in_raddr, in_issue, in_issue_addr,
    input  in_we, in_waddr, in_wdata, in_flush,
    output out_rdata, out_rbusy,
    output out_issue_stall, out_sb_err
  );

endinterface

// File: rtl/grf_scoreboard_pend_ctr.sv
// grf_pend_ctr: per-register in-flight write counter.
// Ports: clk, reset, inc_i, dec_i, flush_i -> cnt_o, sat_o.
module grf_pend_ctr
  import grf_pkg::*;
#(
  parameter int CNT_W = GRF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam int MAX = grf_cnt_max(CNT_W);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      flush_i:
        cnt_d = '0;
      !flush_i && inc_i && !dec_i:
        cnt_d = cnt_q + CNT_W'(1);
      !flush_i && dec_i && !inc_i:
        cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: parametrised GRF with per-register pending-write
// scoreboard, NRD comb read ports, issue stall, flush, sticky error.
// Ports: clk, reset (async, high), bus (grf_scoreboard_if.slave).
// Option: GRF_FWD_EN enables same-cycle writeback forwarding.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NRD    = 2,
  parameter int CNT_W  = GRF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  grf_scoreboard_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] grf_q [DEPTH];
  logic [CNT_W-1:0]  cnt   [DEPTH];
  logic [DEPTH-1:0]  sat;
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;

  logic wr_en;
  logic same_wb;
  logic stall;
  logic sb_err_q;
  logic sb_err_d;

  logic [DATA_W-1:0] rd_d [NRD];
  logic              rd_b [NRD];
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;

  assign wr_en = bus.in_we && (bus.in_waddr != '0);

  // a retiring write to the saturated target frees a slot this cycle
  assign same_wb = wr_en
                && (bus.in_waddr == bus.in_issue_addr)
                && (cnt[bus.in_waddr] != '0);

  assign stall = bus.in_issue
              && (bus.in_issue_addr != '0)
              && sat[bus.in_issue_addr]
              && !same_wb;

  for (genvar r = 0; r < DEPTH; r++) begin : g_ctr
    if (r == 0) begin : g_zero
      assign inc[r] = 1'b0;
      assign dec[r] = 1'b0;
    end else begin : g_reg
      assign inc[r] = bus.in_issue
                   && (bus.in_issue_addr == ADDR_W'(r))
                   && !stall;
      assign dec[r] = wr_en
                   && (bus.in_waddr == ADDR_W'(r))
                   && (cnt[r] != '0);
    end
    grf_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .flush_i (bus.in_flush),
      .cnt_o   (cnt[r]),
      .sat_o   (sat[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) grf_q[i] <= '0;
    end else if (wr_en) begin
      grf_q[bus.in_waddr] <= bus.in_wdata;
    end
  end

  assign sb_err_d = sb_err_q
                 || (wr_en && (cnt[bus.in_waddr] == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              busy;
    assign ra   = bus.in_raddr[k*ADDR_W +: ADDR_W];
    assign busy = (cnt[ra] != '0);
`ifdef GRF_FWD_EN
    logic hit;
    logic last;
    assign hit  = !reset && wr_en && (bus.in_waddr == ra);
    // retiring write is the only one left unless re-issued now
    assign last = (cnt[ra] == CNT_W'(1))
               && !(bus.in_issue && (bus.in_issue_addr == ra));
    assign rd_d[k] = hit ? bus.in_wdata : grf_q[ra];
    assign rd_b[k] = busy && !(hit && last);
`else
    assign rd_d[k] = grf_q[ra];
    assign rd_b[k] = busy;
`endif
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      rdata[k*DATA_W +: DATA_W] = rd_d[k];
      rbusy[k]                  = rd_b[k];
    end
  end

  assign bus.out_rdata       = rdata;
  assign bus.out_rbusy       = rbusy;
  assign bus.out_issue_stall = stall;
  assign bus.out_sb_err      = sb_err_q;

endmodule
